// File: rtl/axi_wr_slave_rcvr_pkg.sv
// Shared types for the write-channel slave receiver: FSM encoding, AW request record,
// line geometry and the address-window / atomic-op acceptance check.
package axi_wr_slave_rcvr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WDATA = 2'd1,
    ST_MWR   = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [5:0] ATOP_NONE = 6'h00;
  localparam int BEATS  = 4;
  localparam int DATA_W = 32;
  localparam int LINE_W = 128;
  localparam int CNT_W  = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [5:0]  atop;
  } aw_req_t;

  // A request is performed only inside the decoded window and only as a plain write.
  function automatic logic req_ok(input aw_req_t req, input logic [31:0] base,
                                  input logic [31:0] mask);
    return ((req.addr & mask) == (base & mask)) && (req.atop == ATOP_NONE);
  endfunction

endpackage

// File: rtl/axi_wr_slave_rcvr_if.sv
// AW/W/B channels plus the memory-side line write port; master = bus/memory side, slave = receiver.
interface axi_wr_slave_rcvr_if;
  logic         awvalid;
  logic         awready;
  logic [3:0]   awid;
  logic [31:0]  awaddr;
  logic [5:0]   awatop;
  logic         wvalid;
  logic         wready;
  logic [31:0]  wdata;
  logic         wlast;
  logic         bvalid;
  logic         bready;
  logic [3:0]   bid;
  logic         bcomp;
  logic         mem_we;
  logic         mem_wready;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;

  modport master (
    output awvalid, awid, awaddr, awatop, wvalid, wdata, wlast, bready, mem_wready,
    input  awready, wready, bvalid, bid, bcomp, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  awvalid, awid, awaddr, awatop, wvalid, wdata, wlast, bready, mem_wready,
    output awready, wready, bvalid, bid, bcomp, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/axi_wr_slave_rcvr_wr_line_assembler.sv
// Packs W beats into a 128-bit line (beat 0 in the low word), flags early/late wlast.
// Zero-latency status on the wlast beat; no backpressure of its own (parent gates beat_vld).
module wr_line_assembler
  import axi_wr_slave_rcvr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              beat_vld,
  input  logic [DATA_W-1:0] beat_dat,
  input  logic              beat_last,
  output logic              done,
  output logic              err,
  output logic [LINE_W-1:0] line
);

  logic [CNT_W-1:0] cnt_q;
  logic             full_q;

  // Once four beats are stored, later beats are swallowed until wlast arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
      line   <= '0;
    end else if (clr) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else if (beat_vld) begin
      if (!full_q) begin
        line[DATA_W*cnt_q +: DATA_W] <= beat_dat;
      end
      if (beat_last) begin
        cnt_q  <= '0;
        full_q <= 1'b0;
      end else if (cnt_q == LAST_BEAT) begin
        full_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign done = beat_vld & beat_last;
  assign err  = done & (full_q | (cnt_q != LAST_BEAT));

endmodule

// File: rtl/axi_wr_slave_rcvr.sv
// Write slave receiver: AW + 4 W beats -> one 128-bit memory write -> B; bvalid in the 7th cycle
// counting the AW handshake cycle, stalls on mem_wready/bready. WR_SLV_AW_PREACCEPT_EN: hold one AW.
module axi_wr_slave_rcvr
  import axi_wr_slave_rcvr_pkg::*;
#(
  parameter logic [31:0] SLV_ADDR_BASE = 32'h0000_0000,
  parameter logic [31:0] SLV_ADDR_MASK = 32'hFFFF_0000
)
(
  input  logic             clk,
  input  logic             rst,
  axi_wr_slave_rcvr_if.slave bus
);

  state_t  state_q, state_d;
  aw_req_t aw_in, cur_q, load_req;
  logic    comp_q;
  logic    aw_hs, w_hs, b_hs, load, ok;
  logic    asm_done, asm_err;

  assign aw_in = {bus.awid, bus.awaddr, bus.awatop};
  assign aw_hs = bus.awvalid & bus.awready;
  assign w_hs  = bus.wvalid & bus.wready;
  assign b_hs  = bus.bvalid & bus.bready;
  assign ok    = req_ok(cur_q, SLV_ADDR_BASE, SLV_ADDR_MASK);

`ifdef WR_SLV_AW_PREACCEPT_EN
  aw_req_t hold_q;
  logic    hold_vld_q;

  // A request arriving on the same cycle as the B handshake bypasses the holding register.
  assign load     = ((state_q == ST_IDLE) & aw_hs) |
                    ((state_q == ST_RESP) & b_hs & (hold_vld_q | aw_hs));
  assign load_req = hold_vld_q ? hold_q : aw_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
    end else if (load & hold_vld_q) begin
      hold_vld_q <= 1'b0;
    end else if (aw_hs & ~load) begin
      hold_vld_q <= 1'b1;
      hold_q     <= aw_in;
    end
  end
`else
  assign load     = (state_q == ST_IDLE) & aw_hs;
  assign load_req = aw_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (load) state_d = ST_WDATA;
      ST_WDATA: if (asm_done) state_d = (asm_err | ~ok) ? ST_RESP : ST_MWR;
      ST_MWR:   if (bus.mem_wready) state_d = ST_RESP;
      ST_RESP:  if (b_hs) state_d = load ? ST_WDATA : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.awready = (state_q == ST_IDLE);
`ifdef WR_SLV_AW_PREACCEPT_EN
    if (((state_q == ST_MWR) || (state_q == ST_RESP)) && !hold_vld_q) begin
      bus.awready = 1'b1;
    end
`endif
    bus.wready = (state_q == ST_WDATA);
    bus.mem_we = (state_q == ST_MWR);
    bus.bvalid = (state_q == ST_RESP);
  end

  // Completion flag is decided on the way into RESP and held until the next response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q  <= '0;
      comp_q <= 1'b0;
    end else begin
      if (load) begin
        cur_q <= load_req;
      end
      if ((state_q == ST_WDATA) && asm_done) begin
        comp_q <= 1'b0;
      end else if ((state_q == ST_MWR) && bus.mem_wready) begin
        comp_q <= 1'b1;
      end
    end
  end

  assign bus.bid      = cur_q.id;
  assign bus.bcomp    = comp_q;
  assign bus.mem_addr = {cur_q.addr[31:4], 4'h0};

  wr_line_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (load),
    .beat_vld  (w_hs),
    .beat_dat  (bus.wdata),
    .beat_last (bus.wlast),
    .done      (asm_done),
    .err       (asm_err),
    .line      (bus.mem_wdata)
  );

endmodule

// File: tb/tb_axi_wr_slave_rcvr.sv
// Bench for axi_wr_slave_rcvr: vector table of bursts plus hand-written backpressure,
// reset and (with WR_SLV_AW_PREACCEPT_EN) pre-accept sequences; scoreboard on mem and B.
module tb_axi_wr_slave_rcvr;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  axi_wr_slave_rcvr_if bus();

  axi_wr_slave_rcvr #(
    .SLV_ADDR_BASE (32'h0000_0000),
    .SLV_ADDR_MASK (32'hFFFF_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [5:0]  atop;
    int          nbeats;
    logic [31:0] seed;
    logic [31:0] step;
    logic        exp_comp;
    logic [31:0] exp_maddr;
    logic        chk_lat;
  } vec_t;

  typedef struct { logic [3:0] id; logic comp; } b_exp_t;
  typedef struct { logic [31:0] addr; logic [127:0] data; } m_exp_t;

  b_exp_t b_q[$];
  m_exp_t m_q[$];
  b_exp_t mon_b;
  m_exp_t mon_m;

  int   n_cmp = 0, n_fail = 0;
  int   b_cnt = 0, m_cnt = 0;
  int   cyc = 0, aw_cyc = 0, last_lat = 0;
  logic bv_prev = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(negedge clk);
    if (rst) begin
      bv_prev = 1'b0;
    end else begin
      if (bus.awvalid && bus.awready) aw_cyc = cyc;
      if (bus.bvalid && !bv_prev) last_lat = cyc - aw_cyc + 1;
      bv_prev = bus.bvalid;
      if (bus.mem_we && bus.mem_wready) begin
        m_cnt++;
        if (m_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL mem_unexpected: write to %0h, none expected", bus.mem_addr);
        end else begin
          mon_m = m_q.pop_front();
          chk("mem_addr", bus.mem_addr, mon_m.addr);
          chk("mem_wdata", bus.mem_wdata, mon_m.data);
        end
      end
      if (bus.bvalid && bus.bready) begin
        b_cnt++;
        if (b_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL b_unexpected: bid %0h, none expected", bus.bid);
        end else begin
          mon_b = b_q.pop_front();
          chk("bid", bus.bid, mon_b.id);
          chk("bcomp", bus.bcomp, mon_b.comp);
        end
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_awready"}, bus.awready, 1);
    chk({tag, "_wready"}, bus.wready, 0);
    chk({tag, "_bvalid"}, bus.bvalid, 0);
    chk({tag, "_bid"}, bus.bid, 0);
    chk({tag, "_bcomp"}, bus.bcomp, 0);
    chk({tag, "_mem_we"}, bus.mem_we, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [5:0] atop);
    int n = 0;
    bus.awvalid = 1'b1; bus.awid = id; bus.awaddr = addr; bus.awatop = atop;
    @(negedge clk);
    while (!bus.awready && n < 100) begin @(negedge clk); n++; end
    chk("aw_handshake", bus.awready, 1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
  endtask

  task automatic drive_beat(input logic [31:0] dat, input logic last);
    int n = 0;
    bus.wvalid = 1'b1; bus.wdata = dat; bus.wlast = last;
    @(negedge clk);
    while (!bus.wready && n < 100) begin @(negedge clk); n++; end
    chk("w_handshake", bus.wready, 1);
    @(posedge clk); #1;
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
  endtask

  task automatic wait_b(input int target);
    int n = 0;
    while (b_cnt < target && n < 100) begin @(posedge clk); n++; end
    if (b_cnt < target) begin
      n_cmp++; n_fail++;
      $display("FAIL b_timeout: got %0d responses, expected %0d", b_cnt, target);
    end
    #1;
  endtask

  function automatic logic [127:0] mk_line(input logic [31:0] seed, input logic [31:0] step);
    logic [127:0] l = '0;
    for (int i = 0; i < 4; i++) l[32*i +: 32] = seed + step * 32'(i);
    return l;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int b0, m0;
    b_exp_t be;
    m_exp_t me;
    be.id = v.id; be.comp = v.exp_comp;
    b_q.push_back(be);
    if (v.exp_comp) begin
      me.addr = v.exp_maddr; me.data = mk_line(v.seed, v.step);
      m_q.push_back(me);
    end
    b0 = b_cnt; m0 = m_cnt;
    send_aw(v.id, v.addr, v.atop);
    for (int i = 0; i < v.nbeats; i++) drive_beat(v.seed + v.step * 32'(i), i == v.nbeats - 1);
    wait_b(b0 + 1);
    chk($sformatf("v%0d_resp_count", idx), b_cnt - b0, 1);
    chk($sformatf("v%0d_mem_writes", idx), m_cnt - m0, {127'b0, v.exp_comp});
    if (v.chk_lat) chk($sformatf("v%0d_aw_to_b_latency", idx), last_lat, 7);
    @(negedge clk);
    chk($sformatf("v%0d_awready_back", idx), bus.awready, 1);
    @(posedge clk); #1;
  endtask

  initial begin #300000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

  initial begin
    vec_t vecs[7];
    vec_t v;
    int   b0, m0, n;
    logic [127:0] bp_line;

    vecs[0] = '{4'h3, 32'h0000_0120, 6'h00, 4, 32'h1111_1111, 32'h1111_1111, 1'b1, 32'h0000_0120, 1'b1};
    vecs[1] = '{4'h5, 32'h0001_0000, 6'h00, 4, 32'hA0A0_A0A0, 32'h0101_0101, 1'b0, 32'h0, 1'b0};
    vecs[2] = '{4'h7, 32'h0000_0040, 6'h00, 2, 32'hDEAD_0000, 32'h0000_0001, 1'b0, 32'h0, 1'b0};
    vecs[3] = '{4'hF, 32'h0000_FFF0, 6'h00, 4, 32'hCAFE_BABE, 32'h1357_9BDF, 1'b1, 32'h0000_FFF0, 1'b1};
    vecs[4] = '{4'h9, 32'h0000_0200, 6'h21, 4, 32'h1234_5678, 32'h1111_0000, 1'b0, 32'h0, 1'b0};
    vecs[5] = '{4'hA, 32'h0000_0330, 6'h00, 6, 32'h5A5A_0000, 32'h0000_0100, 1'b0, 32'h0, 1'b0};
    vecs[6] = '{4'h1, 32'h0000_1237, 6'h00, 4, 32'h0F0F_0F0F, 32'h1010_1010, 1'b1, 32'h0000_1230, 1'b0};

    bus.awvalid = 0; bus.awid = 0; bus.awaddr = 0; bus.awatop = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wlast = 0;
    bus.bready = 1; bus.mem_wready = 1;
    #1 rst = 1'b1;
    @(negedge clk);
    chk_reset("reset");
    @(posedge clk); #1 rst = 1'b0;

    // W beats offered before any AW must not be taken.
    bus.wvalid = 1; bus.wdata = 32'hBAD0_BAD0; bus.wlast = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("idle_wready", bus.wready, 0);
      @(posedge clk); #1;
    end
    bus.wvalid = 0; bus.wlast = 0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Memory and response backpressure.
    bp_line = mk_line(32'hB000_0001, 32'h0000_0010);
    bus.bready = 0; bus.mem_wready = 0;
    b_q.push_back('{4'h2, 1'b1});
    m_q.push_back('{32'h0000_0500, bp_line});
    b0 = b_cnt; m0 = m_cnt;
    send_aw(4'h2, 32'h0000_0500, 6'h00);
    for (int i = 0; i < 4; i++) drive_beat(32'hB000_0001 + 32'h10 * 32'(i), i == 3);
    n = 0;
    @(negedge clk);
    while (!bus.mem_we && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_mem_we_hold", bus.mem_we, 1);
      chk("bp_mem_addr_hold", bus.mem_addr, 32'h0000_0500);
      chk("bp_mem_wdata_hold", bus.mem_wdata, bp_line);
      chk("bp_bvalid_low", bus.bvalid, 0);
    end
    @(posedge clk); #1 bus.mem_wready = 1;
    n = 0;
    @(negedge clk);
    while (!bus.bvalid && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_bvalid_hold", bus.bvalid, 1);
      chk("bp_bid_hold", bus.bid, 4'h2);
      chk("bp_bcomp_hold", bus.bcomp, 1);
      chk("bp_mem_we_off", bus.mem_we, 0);
    end
    @(posedge clk); #1 bus.bready = 1;
    wait_b(b0 + 1);
    chk("bp_single_write", m_cnt - m0, 1);
    chk("bp_single_resp", b_cnt - b0, 1);

    // Reset while the third beat is on the bus.
    b0 = b_cnt; m0 = m_cnt;
    send_aw(4'h4, 32'h0000_0080, 6'h00);
    drive_beat(32'h7000_0000, 1'b0);
    drive_beat(32'h7000_0001, 1'b0);
    bus.wvalid = 1; bus.wdata = 32'h7000_0002; bus.wlast = 0;
    #2 rst = 1'b1;
    #1 chk_reset("midrst");
    bus.wvalid = 0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_write", m_cnt - m0, 0);
    chk("midrst_no_resp", b_cnt - b0, 0);
    v = '{4'h6, 32'h0000_0090, 6'h00, 4, 32'h8000_0000, 32'h0000_0003, 1'b1, 32'h0000_0090, 1'b1};
    run_vec(v, 7);

`ifdef WR_SLV_AW_PREACCEPT_EN
    // Second AW accepted during RESP, then WDATA immediately after the B handshake.
    bus.bready = 0;
    b_q.push_back('{4'h8, 1'b0});
    b_q.push_back('{4'h9, 1'b1});
    m_q.push_back('{32'h0000_0700, mk_line(32'hC000_0000, 32'h0000_0005)});
    b0 = b_cnt; m0 = m_cnt;
    send_aw(4'h8, 32'h0000_0600, 6'h21);
    for (int i = 0; i < 4; i++) drive_beat(32'h9000_0000 + 32'(i), i == 3);
    send_aw(4'h9, 32'h0000_0700, 6'h00);
    @(negedge clk);
    chk("pa_awready_full", bus.awready, 0);
    chk("pa_bvalid", bus.bvalid, 1);
    @(posedge clk); #1 bus.bready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pa_wready_no_idle", bus.wready, 1);
    chk("pa_bvalid_low", bus.bvalid, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) drive_beat(32'hC000_0000 + 32'h5 * 32'(i), i == 3);
    wait_b(b0 + 2);
    chk("pa_writes", m_cnt - m0, 1);
`endif

    repeat (2) @(posedge clk);
    chk("b_queue_drained", b_q.size(), 0);
    chk("m_queue_drained", m_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
